// File: rtl/sha256_pkg.sv
// Shared state type, block constants and the final-word masking helper
// used by the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_EMIT
    } state_t;

    localparam int          WORDS_PER_BLOCK = 16;
    localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
    localparam int          LEN_W           = 64;

    function automatic logic [2:0] clamp_bytes(input logic [2:0] nbytes);
        return (nbytes > 3'd4) ? 3'd4 : nbytes;
    endfunction

    // Keeps the leading nbytes bytes (big-endian), zeroes the rest and puts the
    // 0x80 terminator right after the data when the word still has room for it.
    function automatic logic [31:0] mask_final_word(input logic [31:0] data,
                                                    input logic [2:0]  nbytes);
        logic [31:0] result;
        logic [2:0]  n;
        n      = clamp_bytes(nbytes);
        result = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < n)
                result[31-8*k -: 8] = data[31-8*k -: 8];
            else if (3'(k) == n)
                result[31-8*k -: 8] = 8'h80;
        end
        return result;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Message-word input stream and padded-block output stream of the padder.
interface sha256_padder_if;

    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;

    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;

    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_last
    );

endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 terminator, zero fill and the 64-bit bit length.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = sha256_pkg::LEN_W
) (
    input  logic           clk,
    input  logic           reset,
    sha256_padder_if.slave bus,
    output logic           busy
);

    state_t             state;
    state_t             state_next;
    logic [4:0]         widx;
    logic [31:0]        words [WORDS_PER_BLOCK];
    logic [LEN_W-1:0]   len;
    logic               pad_pending;
    logic               msg_padding;
    logic               first_q;
    logic               last_q;
    logic               ready_en;
    logic               accept;
    logic [2:0]         eff_bytes;

    assign eff_bytes = clamp_bytes(bus.in_bytes);
    assign accept    = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_FILL;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.blk_valid = 1'b0;
        case (state)
            S_FILL: begin
                bus.in_ready = ready_en;
                if (ready_en && bus.in_valid) begin
                    if (bus.in_last)
                        state_next = S_PAD;
                    else if (widx == 5'd15)
                        state_next = S_EMIT;
                end
            end
            S_PAD: begin
                if (widx == 5'd16 || (widx == 5'd14 && !pad_pending))
                    state_next = S_EMIT;
            end
            S_EMIT: begin
                bus.blk_valid = 1'b1;
                // A block that ran out of room mid-padding resumes padding in a fresh buffer.
                if (bus.blk_ready)
                    state_next = (msg_padding && !last_q) ? S_PAD : S_FILL;
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            widx        <= '0;
            words       <= '{default: '0};
            len         <= '0;
            pad_pending <= 1'b0;
            msg_padding <= 1'b0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            ready_en    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        widx <= widx + 5'd1;
                        if (bus.in_last) begin
                            words[widx[3:0]] <= mask_final_word(bus.in_data, bus.in_bytes);
                            len              <= len + LEN_W'({eff_bytes, 3'b000});
                            pad_pending      <= (eff_bytes == 3'd4);
                            msg_padding      <= 1'b1;
                        end else begin
                            words[widx[3:0]] <= bus.in_data;
                            len              <= len + LEN_W'(32);
                        end
                    end
                end
                S_PAD: begin
                    if (widx == 5'd14 && !pad_pending) begin
                        words[14] <= len[LEN_W-1 -: 32];
                        words[15] <= len[31:0];
                        last_q    <= 1'b1;
                    end else if (widx != 5'd16) begin
                        words[widx[3:0]] <= pad_pending ? PAD_WORD : 32'h0;
                        pad_pending      <= 1'b0;
                        widx             <= widx + 5'd1;
                    end
                end
                S_EMIT: begin
                    if (bus.blk_ready) begin
                        widx   <= '0;
                        words  <= '{default: '0};
                        last_q <= 1'b0;
                        if (last_q) begin
                            len         <= '0;
                            msg_padding <= 1'b0;
                            first_q     <= 1'b1;
                        end else begin
                            first_q     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.blk_data = '0;
        for (int i = 0; i < WORDS_PER_BLOCK; i++)
            bus.blk_data[32*i +: 32] = words[i];
    end

    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;

    // first_q low means a message has already produced a block and is still open.
    assign busy = (state != S_FILL) || (widx != 5'd0) || !first_q;

endmodule
